// File: rtl/riscv_data_router_pkg.sv
// Shared definitions for the core data-port router.
//  - peripheral address map (TX character port, timer, peripheral window)
//  - FSM state encoding
//  - access-route encoding and the address decoder used in the IDLE decode cycle
package riscv_data_router_pkg;

  localparam logic [31:0] ADDR_TX     = 32'h4000_0004;
  localparam logic [31:0] ADDR_TIMER  = 32'h4000_0008;
  // Upper 24 bits of the 256-byte peripheral window 0x400000xx.
  localparam logic [23:0] PERIPH_BASE = 24'h40_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUS,
    ST_PERIPH,
    ST_PERIPH_TX,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    RT_BUS,
    RT_TX,
    RT_TIMER,
    RT_FAULT
  } route_t;

  // Exact peripheral matches take priority over the window check, so any
  // unmapped 0x400000xx address faults instead of falling through to RAM.
  function automatic route_t decode_route(input logic [31:0] addr,
                                          input logic        rd,
                                          input logic        wr,
                                          input logic [31:0] ram_lo,
                                          input logic [31:0] ram_hi);
    route_t r;
    if (rd && wr)                         r = RT_FAULT;
    else if (addr == ADDR_TX)             r = RT_TX;
    else if (addr == ADDR_TIMER)          r = RT_TIMER;
    else if (addr[31:8] == PERIPH_BASE)   r = RT_FAULT;
    else if (addr >= ram_lo && addr < ram_hi) r = RT_BUS;
    else                                  r = RT_FAULT;
    return r;
  endfunction

endpackage

// File: rtl/riscv_data_router_periph_timer.sv
// Free-running timer: a divider counts 0..TIMER_DIV and the 32-bit value
// advances once per full divider period (wrapping at 2^32).
// Ports:
//  clock, reset      clock and synchronous active-high reset
//  load, load_value  load the timer and restart the divider (beats a same-cycle tick)
//  value             current timer value
module riscv_data_router_periph_timer #(
  parameter int TIMER_DIV = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] value
);

  localparam int DW = (TIMER_DIV < 1) ? 1 : $clog2(TIMER_DIV + 1);

  logic [DW-1:0] divider;

  always_ff @(posedge clock) begin
    if (reset) begin
      divider <= '0;
      value   <= '0;
    end else if (load) begin
      divider <= '0;
      value   <= load_value;
    end else if (divider == DW'(TIMER_DIV)) begin
      divider <= '0;
      value   <= value + 32'd1;
    end else begin
      divider <= divider + DW'(1);
    end
  end

endmodule

// File: rtl/riscv_data_router.sv
// Core data-port router. Decodes each core access and sends it to the cache
// bus (RAM), the TX character port or the timer, returning a one-cycle
// core_ready pulse. Illegal accesses park the router in a sticky FAULT state.
// Ports:
//  clock, reset                 clock and synchronous active-high reset
//  core_*                       core data port (request held until core_ready)
//  bus_read/bus_write           strobes to RiscVBus; bus_rdata/bus_ready back
//  tx_data/tx_valid/tx_ready    debug character sink
//  fault/fault_address          sticky fault flag and first faulting address
module riscv_data_router
  import riscv_data_router_pkg::*;
#(
  parameter int MEM_BYTES   = 65536,
  parameter int GUARD_BYTES = 256,
  parameter int TIMER_DIV   = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [1:0]  core_width,
  input  logic [31:0] core_wdata,
  input  logic        core_read,
  input  logic        core_write,
  output logic [31:0] core_rdata,
  output logic        core_ready,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fault,
  output logic [31:0] fault_address
);

  state_t      state, state_next;
  route_t      route;
  logic        req;
  logic        is_write_q;
  logic [31:0] rdata_q;
  logic [31:0] fault_address_q;
  logic [31:0] timer_value;
  logic        timer_load;

  // Width only matters downstream on the bus, which is wired outside this block.
  logic unused_width;
  assign unused_width = ^core_width;

  assign req   = core_read | core_write;
  assign route = decode_route(core_address, core_read, core_write,
                              32'(GUARD_BYTES), 32'(MEM_BYTES));

  assign timer_load = (state == ST_IDLE) && core_write && (route == RT_TIMER);

  riscv_data_router_periph_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (core_wdata),
    .value      (timer_value)
  );

  // State register plus the values captured in the decode cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      is_write_q      <= 1'b0;
      rdata_q         <= '0;
      fault_address_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req) begin
        is_write_q <= core_write;
        case (route)
          RT_TX:    rdata_q         <= {31'b0, tx_ready};
          RT_TIMER: rdata_q         <= timer_value;
          RT_FAULT: fault_address_q <= core_address;
          default:  ;
        endcase
      end
    end
  end

  // Next state. A RAM access that completes in its decode cycle never enters BUS.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          case (route)
            RT_BUS:   if (!bus_ready) state_next = ST_BUS;
            RT_TX:    state_next = core_write ? ST_PERIPH_TX : ST_PERIPH;
            RT_TIMER: state_next = ST_PERIPH;
            default:  state_next = ST_FAULT;
          endcase
        end
      end
      ST_BUS:       if (bus_ready) state_next = ST_IDLE;
      ST_PERIPH:    state_next = ST_IDLE;
      ST_PERIPH_TX: if (tx_ready) state_next = ST_PERIPH;
      ST_FAULT:     state_next = ST_FAULT;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs. Everything is forced quiet while reset is high so an aborted
  // access produces no strobe in the reset cycle.
  always_comb begin
    core_ready    = 1'b0;
    core_rdata    = rdata_q;
    bus_read      = 1'b0;
    bus_write     = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    fault         = 1'b0;
    fault_address = fault_address_q;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (req && route == RT_BUS) begin
            bus_read   = core_read;
            bus_write  = core_write;
            core_ready = bus_ready;
            core_rdata = bus_rdata;
          end
        end
        ST_BUS: begin
          bus_read   = !is_write_q;
          bus_write  = is_write_q;
          core_ready = bus_ready;
          core_rdata = bus_rdata;
        end
        ST_PERIPH:    core_ready = 1'b1;
        ST_PERIPH_TX: begin
          tx_valid = tx_ready;
          tx_data  = tx_ready ? core_wdata[7:0] : 8'h00;
        end
        ST_FAULT:     fault = 1'b1;
        default:      ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_data_router.sv
module tb_riscv_data_router;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] core_address;
  logic [1:0]  core_width;
  logic [31:0] core_wdata;
  logic        core_read, core_write;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic        bus_read, bus_write;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        fault;
  logic [31:0] fault_address;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  riscv_data_router dut (
    .clock         (clock),
    .reset         (reset),
    .core_address  (core_address),
    .core_width    (core_width),
    .core_wdata    (core_wdata),
    .core_read     (core_read),
    .core_write    (core_write),
    .core_rdata    (core_rdata),
    .core_ready    (core_ready),
    .bus_read      (bus_read),
    .bus_write     (bus_write),
    .bus_rdata     (bus_rdata),
    .bus_ready     (bus_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .fault         (fault),
    .fault_address (fault_address)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rd, wr;
    logic [1:0]  w;
    logic [31:0] wdata;
    logic        txr;
    int          bus_delay;
    logic [31:0] bdata;
    logic        exp_fault;
    int          exp_lat;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_rd, exp_wr, exp_tx;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive phase is 1 time unit after posedge; sampling is at negedge.
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; core_read = 1'b0; core_write = 1'b0; bus_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // One core access, held until core_ready or until the cycle budget runs out.
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [1:0] w, input logic [31:0] wdata, input logic txr,
                        input int bus_delay, input logic [31:0] bdata, input int budget,
                        output logic got, output int lat, output logic [31:0] rdata,
                        output int nrd, output int nwr, output int ntx, output logic [7:0] txd);
    got = 1'b0; lat = -1; rdata = '0; nrd = 0; nwr = 0; ntx = 0; txd = '0;
    core_address = addr; core_read = rd; core_write = wr; core_width = w;
    core_wdata = wdata; tx_ready = txr; bus_rdata = bdata;
    for (int c = 0; c < budget && !got; c++) begin
      bus_ready = (c == bus_delay);
      @(negedge clock);
      if (bus_read)  nrd++;
      if (bus_write) nwr++;
      if (tx_valid) begin ntx++; txd = tx_data; end
      if (core_ready) begin got = 1'b1; lat = c; rdata = core_rdata; end
      step();
    end
    core_read = 1'b0; core_write = 1'b0; bus_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        got, any_tx, any_rdy, any_bw;
    int          lat, nrd, nwr, ntx;
    logic [31:0] rdata;
    logic [7:0]  txd;

    //            addr          rd wr  w  wdata         txr dly bdata        flt lat chk exp_rdata    rd wr tx txd
    vecs[0]  = '{32'h0000_1000, 1, 0, 2, 32'h0,         0,  2, 32'hDEAD_BEEF, 0, 2, 1, 32'hDEAD_BEEF, 3, 0, 0, 8'h00};
    vecs[1]  = '{32'h0000_2000, 0, 1, 2, 32'h1234_5678, 0,  0, 32'h0,         0, 0, 0, 32'h0,         0, 1, 0, 8'h00};
    vecs[2]  = '{32'h0000_0100, 1, 0, 2, 32'h0,         0,  1, 32'hA5A5_0001, 0, 1, 1, 32'hA5A5_0001, 2, 0, 0, 8'h00};
    vecs[3]  = '{32'h0000_FFFC, 1, 0, 2, 32'h0,         0,  3, 32'h0BAD_F00D, 0, 3, 1, 32'h0BAD_F00D, 4, 0, 0, 8'h00};
    vecs[4]  = '{32'h0000_FFFF, 0, 1, 0, 32'h0000_00EE, 0,  1, 32'h0,         0, 1, 0, 32'h0,         0, 2, 0, 8'h00};
    vecs[5]  = '{32'h4000_0004, 0, 1, 0, 32'h0000_0041, 1,  0, 32'h0,         0, 2, 0, 32'h0,         0, 0, 1, 8'h41};
    vecs[6]  = '{32'h4000_0004, 0, 1, 2, 32'h1234_56C3, 1,  1, 32'h0,         0, 2, 0, 32'h0,         0, 0, 1, 8'hC3};
    vecs[7]  = '{32'h4000_0004, 1, 0, 2, 32'h0,         1,  0, 32'hFFFF_FFFF, 0, 1, 1, 32'h0000_0001, 0, 0, 0, 8'h00};
    vecs[8]  = '{32'h4000_0004, 1, 0, 1, 32'h0,         0,  0, 32'hFFFF_FFFF, 0, 1, 1, 32'h0000_0000, 0, 0, 0, 8'h00};
    vecs[9]  = '{32'h0000_0010, 1, 0, 2, 32'h0,         1,  0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 8'h00};
    vecs[10] = '{32'h0000_00FF, 0, 1, 0, 32'h0,         1,  0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 8'h00};
    vecs[11] = '{32'h0001_0000, 1, 0, 2, 32'h0,         1,  0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 8'h00};
    vecs[12] = '{32'h4000_0010, 1, 0, 2, 32'h0,         1,  0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 8'h00};
    vecs[13] = '{32'h4000_0004, 1, 1, 0, 32'h41,        1,  0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 8'h00};
    vecs[14] = '{32'h0000_1000, 1, 1, 2, 32'h0,         1,  0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 8'h00};

    core_address = '0; core_width = 2'd2; core_wdata = '0; core_read = 1'b0;
    core_write = 1'b0; bus_rdata = '0; bus_ready = 1'b0; tx_ready = 1'b0;

    // Reset: outputs quiet, and a RAM request during reset issues no strobe.
    reset = 1'b1;
    repeat (2) step();
    core_address = 32'h1000; core_read = 1'b1; bus_ready = 1'b1;
    @(negedge clock);
    check("rst.bus_read", bus_read, 1'b0);
    check("rst.core_ready", core_ready, 1'b0);
    step();
    reset = 1'b0; core_read = 1'b0; bus_ready = 1'b0;
    @(negedge clock);
    check("rst.fault", fault, 1'b0);
    check("rst.fault_address", fault_address, 32'h0);
    check("rst.core_rdata", core_rdata, 32'h0);
    check("rst.tx_valid", tx_valid, 1'b0);
    check("rst.tx_data", tx_data, 8'h00);
    check("rst.bus_write", bus_write, 1'b0);

    // Timer: three ticks after 303 clocks.
    repeat (303) step();
    access(32'h4000_0008, 1, 0, 2, 0, 0, 0, 32'hFFFF_FFFF, 8, got, lat, rdata, nrd, nwr, ntx, txd);
    check("timer303.got", got, 1'b1);
    check("timer303.lat", 32'(lat), 32'd1);
    check("timer303.value", rdata, 32'd3);
    check("timer303.nobus", 32'(nrd + nwr), 32'd0);

    // Table of single accesses (fault rows get a reset afterwards).
    foreach (vecs[i]) begin
      access(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].w, vecs[i].wdata, vecs[i].txr,
             vecs[i].bus_delay, vecs[i].bdata, vecs[i].exp_fault ? 6 : 12,
             got, lat, rdata, nrd, nwr, ntx, txd);
      check($sformatf("v%0d.ready", i), got, !vecs[i].exp_fault);
      check($sformatf("v%0d.bus_read_cycles", i), 32'(nrd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d.bus_write_cycles", i), 32'(nwr), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d.tx_pulses", i), 32'(ntx), 32'(vecs[i].exp_tx));
      if (vecs[i].exp_fault) begin
        @(negedge clock);
        check($sformatf("v%0d.fault", i), fault, 1'b1);
        check($sformatf("v%0d.fault_address", i), fault_address, vecs[i].addr);
        if (i == 9) begin
          access(32'h1000, 1, 0, 2, 0, 1, 0, 32'h1111_1111, 6, got, lat, rdata, nrd, nwr, ntx, txd);
          check("fault.later_ready", got, 1'b0);
          check("fault.later_bus", 32'(nrd + nwr), 32'd0);
          @(negedge clock);
          check("fault.addr_kept", fault_address, 32'h10);
        end
        step();
        do_reset();
        @(negedge clock);
        check($sformatf("v%0d.fault_cleared", i), fault, 1'b0);
        step();
      end else begin
        check($sformatf("v%0d.lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        if (vecs[i].chk_rdata) check($sformatf("v%0d.rdata", i), rdata, vecs[i].exp_rdata);
        if (vecs[i].exp_tx != 0) check($sformatf("v%0d.tx_data", i), 32'(txd), 32'(vecs[i].exp_txd));
      end
    end

    // Timer load then wrap.
    access(32'h4000_0008, 0, 1, 0, 32'hFFFF_FFFF, 0, -1, 0, 8, got, lat, rdata, nrd, nwr, ntx, txd);
    check("tload.lat", 32'(lat), 32'd1);
    access(32'h4000_0008, 1, 0, 2, 0, 0, -1, 0, 8, got, lat, rdata, nrd, nwr, ntx, txd);
    check("tload.value", rdata, 32'hFFFF_FFFF);
    repeat (101) step();
    access(32'h4000_0008, 1, 0, 2, 0, 0, -1, 0, 8, got, lat, rdata, nrd, nwr, ntx, txd);
    check("twrap.value", rdata, 32'h0);

    // TX stall: nothing happens until tx_ready rises.
    core_address = 32'h4000_0004; core_write = 1'b1; core_wdata = 32'h41;
    core_width = 2'd0; tx_ready = 1'b0;
    any_tx = 1'b0; any_rdy = 1'b0; any_bw = 1'b0;
    repeat (6) begin
      @(negedge clock);
      any_tx |= tx_valid; any_rdy |= core_ready; any_bw |= bus_write;
      step();
    end
    check("stall.tx_valid", any_tx, 1'b0);
    check("stall.core_ready", any_rdy, 1'b0);
    tx_ready = 1'b1;
    @(negedge clock);
    check("stall.tx_pulse", tx_valid, 1'b1);
    check("stall.tx_data", tx_data, 8'h41);
    check("stall.early_ready", core_ready, 1'b0);
    any_bw |= bus_write;
    step();
    @(negedge clock);
    check("stall.ready", core_ready, 1'b1);
    check("stall.tx_single", tx_valid, 1'b0);
    any_bw |= bus_write;
    step();
    core_write = 1'b0; tx_ready = 1'b0;
    check("stall.no_bus_write", any_bw, 1'b0);

    // Reset while in BUS aborts the access.
    core_address = 32'h3000; core_read = 1'b1; core_width = 2'd2; bus_ready = 1'b0;
    step();
    @(negedge clock);
    check("rbus.in_bus", bus_read, 1'b1);
    step();
    reset = 1'b1; bus_ready = 1'b1;
    @(negedge clock);
    check("rbus.reset_bus_read", bus_read, 1'b0);
    check("rbus.reset_ready", core_ready, 1'b0);
    step();
    reset = 1'b0; core_read = 1'b0;
    @(negedge clock);
    check("rbus.idle_bus_read", bus_read, 1'b0);
    check("rbus.idle_ready", core_ready, 1'b0);
    step();
    bus_ready = 1'b0;
    access(32'h1000, 1, 0, 2, 0, 0, 1, 32'h5555_AAAA, 8, got, lat, rdata, nrd, nwr, ntx, txd);
    check("rbus.recover_lat", 32'(lat), 32'd1);
    check("rbus.recover_rdata", rdata, 32'h5555_AAAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
